// File: rtl/decoder_pkg.sv
// Shared types for the main instruction decoder.
// DECODER_CARRY_OPS_EN enables distinct ADC/SBC/RSC ALU operations.
package decoder_pkg;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_UND = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        CMD_AND = 4'b0000,
        CMD_EOR = 4'b0001,
        CMD_SUB = 4'b0010,
        CMD_RSB = 4'b0011,
        CMD_ADD = 4'b0100,
        CMD_ADC = 4'b0101,
        CMD_SBC = 4'b0110,
        CMD_RSC = 4'b0111,
        CMD_TST = 4'b1000,
        CMD_TEQ = 4'b1001,
        CMD_CMP = 4'b1010,
        CMD_CMN = 4'b1011,
        CMD_ORR = 4'b1100,
        CMD_MOV = 4'b1101,
        CMD_BIC = 4'b1110,
        CMD_MVN = 4'b1111
    } cmd_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_ADC = 3'b100,
        ALU_SBC = 3'b101,
        ALU_EOR = 3'b110
    } alu_ctl_e;

    typedef enum logic [1:0] {
        IMM_DP  = 2'b00,
        IMM_MEM = 2'b01,
        IMM_BR  = 2'b10
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_OPB = 2'b01,
        RES_MEM = 2'b10
    } res_src_e;

    // Carry-using commands fall back to plain add/sub without the option.
`ifdef DECODER_CARRY_OPS_EN
    localparam alu_ctl_e ALU_ADC_OP = ALU_ADC;
    localparam alu_ctl_e ALU_SBC_OP = ALU_SBC;
`else
    localparam alu_ctl_e ALU_ADC_OP = ALU_ADD;
    localparam alu_ctl_e ALU_SBC_OP = ALU_SUB;
`endif

    typedef struct packed {
        logic       pcs;
        logic       reg_w;
        logic       mem_w;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_src;
        logic       no_write;
        logic       swap;
        logic       inv;
        logic [1:0] flag_w;
        logic [1:0] imm_src;
        logic [1:0] result_src;
        logic [2:0] alu_ctl;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Data-processing command decode: cmd/S to ALU controls.
// DECODER_CARRY_OPS_EN selects real carry ops for ADC/SBC/RSC.
module alu_decoder
    import decoder_pkg::*;
(
    input  logic [3:0] cmd_i,
    input  logic       s_i,
    output logic [2:0] alu_ctl_o,
    output logic [1:0] flag_w_o,
    output logic       swap_o,
    output logic       inv_o,
    output logic       no_write_o,
    output logic [1:0] result_src_o
);

    logic arith;

    // Per-command ALU op, operand tweaks and flag-write class
    always_comb begin
        alu_ctl_o    = ALU_ADD;
        swap_o       = 1'b0;
        inv_o        = 1'b0;
        no_write_o   = 1'b0;
        result_src_o = RES_ALU;
        arith        = 1'b0;
        case (cmd_i)
            CMD_AND: alu_ctl_o = ALU_AND;
            CMD_EOR: alu_ctl_o = ALU_EOR;
            CMD_SUB: begin
                alu_ctl_o = ALU_SUB;
                arith     = 1'b1;
            end
            CMD_RSB: begin
                alu_ctl_o = ALU_SUB;
                swap_o    = 1'b1;
                arith     = 1'b1;
            end
            CMD_ADD: arith = 1'b1;
            CMD_ADC: begin
                alu_ctl_o = ALU_ADC_OP;
                arith     = 1'b1;
            end
            CMD_SBC: begin
                alu_ctl_o = ALU_SBC_OP;
                arith     = 1'b1;
            end
            CMD_RSC: begin
                alu_ctl_o = ALU_SBC_OP;
                swap_o    = 1'b1;
                arith     = 1'b1;
            end
            CMD_TST: begin
                alu_ctl_o  = ALU_AND;
                no_write_o = 1'b1;
            end
            CMD_TEQ: begin
                alu_ctl_o  = ALU_EOR;
                no_write_o = 1'b1;
            end
            CMD_CMP: begin
                alu_ctl_o  = ALU_SUB;
                no_write_o = 1'b1;
                arith      = 1'b1;
            end
            CMD_CMN: begin
                no_write_o = 1'b1;
                arith      = 1'b1;
            end
            CMD_ORR: alu_ctl_o = ALU_ORR;
            CMD_MOV: result_src_o = RES_OPB;
            CMD_BIC: begin
                alu_ctl_o = ALU_AND;
                inv_o     = 1'b1;
            end
            CMD_MVN: begin
                result_src_o = RES_OPB;
                inv_o        = 1'b1;
            end
            default: ;
        endcase
        flag_w_o = s_i ? (arith ? 2'b11 : 2'b10) : 2'b00;
    end

endmodule

// File: rtl/decoder.sv
// Main decoder: op/funct/rd to registered datapath controls.
// DECODER_CARRY_OPS_EN enables distinct ADC/SBC/RSC ALU operations.
module decoder
    import decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    output logic       pcs,
    output logic       reg_w,
    output logic       mem_w,
    output logic       mem_to_reg,
    output logic       alu_src,
    output logic       reg_src,
    output logic       no_write,
    output logic       swap,
    output logic       inv,
    output logic [1:0] flag_w,
    output logic [1:0] imm_src,
    output logic [1:0] result_src,
    output logic [2:0] alu_ctl
);

    ctrl_t      ctrl_d;
    ctrl_t      ctrl_q;
    logic [2:0] dp_alu_ctl;
    logic [1:0] dp_flag_w;
    logic       dp_swap;
    logic       dp_inv;
    logic       dp_no_write;
    logic [1:0] dp_result_src;

    alu_decoder u_alu_decoder (
        .cmd_i        (funct[4:1]),
        .s_i          (funct[0]),
        .alu_ctl_o    (dp_alu_ctl),
        .flag_w_o     (dp_flag_w),
        .swap_o       (dp_swap),
        .inv_o        (dp_inv),
        .no_write_o   (dp_no_write),
        .result_src_o (dp_result_src)
    );

    // Instruction-class decode plus PC-write detection
    always_comb begin
        ctrl_d = '0;
        unique case (op)
            OP_DP: begin
                ctrl_d.alu_src    = funct[5];
                ctrl_d.imm_src    = IMM_DP;
                ctrl_d.alu_ctl    = dp_alu_ctl;
                ctrl_d.flag_w     = dp_flag_w;
                ctrl_d.swap       = dp_swap;
                ctrl_d.inv        = dp_inv;
                ctrl_d.no_write   = dp_no_write;
                ctrl_d.reg_w      = ~dp_no_write;
                ctrl_d.result_src = dp_result_src;
            end
            OP_MEM: begin
                ctrl_d.alu_src = 1'b1;
                ctrl_d.imm_src = IMM_MEM;
                ctrl_d.alu_ctl = funct[3] ? ALU_ADD : ALU_SUB;
                if (funct[0]) begin
                    ctrl_d.reg_w      = 1'b1;
                    ctrl_d.mem_to_reg = 1'b1;
                    ctrl_d.result_src = RES_MEM;
                end else begin
                    ctrl_d.mem_w = 1'b1;
                end
            end
            OP_BR: begin
                ctrl_d.alu_src = 1'b1;
                ctrl_d.imm_src = IMM_BR;
                ctrl_d.reg_src = 1'b1;
                ctrl_d.alu_ctl = ALU_ADD;
                ctrl_d.pcs     = 1'b1;
            end
            default: ;
        endcase
        ctrl_d.pcs = ctrl_d.pcs | (ctrl_d.reg_w & (rd == 4'd15));
    end

    // Control half of the decode pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign pcs        = ctrl_q.pcs;
    assign reg_w      = ctrl_q.reg_w;
    assign mem_w      = ctrl_q.mem_w;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_src    = ctrl_q.alu_src;
    assign reg_src    = ctrl_q.reg_src;
    assign no_write   = ctrl_q.no_write;
    assign swap       = ctrl_q.swap;
    assign inv        = ctrl_q.inv;
    assign flag_w     = ctrl_q.flag_w;
    assign imm_src    = ctrl_q.imm_src;
    assign result_src = ctrl_q.result_src;
    assign alu_ctl    = ctrl_q.alu_ctl;

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for the main decoder with a table-driven model.
// Follows DECODER_CARRY_OPS_EN for the expected carry-op encodings.
module tb_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       pcs, reg_w, mem_w, mem_to_reg, alu_src, reg_src;
    logic       no_write, swap, inv;
    logic [1:0] flag_w, imm_src, result_src;
    logic [2:0] alu_ctl;

    int n_chk  = 0;
    int n_pass = 0;
    logic [17:0] exp_q[$];

    decoder dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .rd(rd),
        .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src),
        .reg_src(reg_src), .no_write(no_write), .swap(swap),
        .inv(inv), .flag_w(flag_w), .imm_src(imm_src),
        .result_src(result_src), .alu_ctl(alu_ctl)
    );

    always #5 clk = ~clk;

    // ALU op per cmd, index = cmd value
`ifdef DECODER_CARRY_OPS_EN
    localparam logic [2:0] ALU_TAB [16] = '{3'd2, 3'd6, 3'd1, 3'd1,
        3'd0, 3'd4, 3'd5, 3'd5, 3'd2, 3'd6, 3'd1, 3'd0,
        3'd3, 3'd0, 3'd2, 3'd0};
`else
    localparam logic [2:0] ALU_TAB [16] = '{3'd2, 3'd6, 3'd1, 3'd1,
        3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd6, 3'd1, 3'd0,
        3'd3, 3'd0, 3'd2, 3'd0};
`endif
    localparam logic [15:0] ARITH_SET = 16'b0000_1100_1111_1100;

    function automatic logic [17:0] model(logic [1:0] o, logic [5:0] f,
                                          logic [3:0] r);
        logic p, rw, mw, m2r, as, rs, nw, sw, iv;
        logic [1:0] fw, is, res;
        logic [2:0] ac;
        int c;
        {p, rw, mw, m2r, as, rs, nw, sw, iv} = '0;
        fw = 0; is = 0; res = 0; ac = 0;
        c = int'(f[4:1]);
        if (o == 2'd0) begin
            ac  = ALU_TAB[c];
            nw  = (c >= 8 && c <= 11);
            sw  = (c == 3 || c == 7);
            iv  = (c >= 14);
            res = (c == 13 || c == 15) ? 2'd1 : 2'd0;
            fw  = !f[0] ? 2'd0 : (ARITH_SET[c] ? 2'd3 : 2'd2);
            rw  = !nw;
            as  = f[5];
        end else if (o == 2'd1) begin
            as = 1; is = 2'd1;
            ac = f[3] ? 3'd0 : 3'd1;
            if (f[0]) begin
                rw = 1; m2r = 1; res = 2'd2;
            end else begin
                mw = 1;
            end
        end else if (o == 2'd2) begin
            as = 1; is = 2'd2; rs = 1; p = 1;
        end
        p = p | (rw && r == 4'd15);
        return {p, rw, mw, m2r, as, rs, nw, sw, iv, fw, is, res, ac};
    endfunction

    function automatic logic [17:0] got();
        return {pcs, reg_w, mem_w, mem_to_reg, alu_src, reg_src,
                no_write, swap, inv, flag_w, imm_src, result_src, alu_ctl};
    endfunction

    task automatic check(string name, logic [17:0] g, logic [17:0] e);
        n_chk++;
        if (g === e) n_pass++;
        else $display("FAIL %s got=%b exp=%b", name, g, e);
    endtask

    // Inputs change on the falling edge; expectation queued at once
    task automatic drive(logic [1:0] o, logic [5:0] f, logic [3:0] r);
        op = o; funct = f; rd = r;
        exp_q.push_back(model(o, f, r));
        @(negedge clk);
    endtask

    // Monitor: compare registered outputs just after each rising edge
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0)
            check("dec", got(), exp_q.pop_front());
    end

    localparam int ND = 18;
    localparam logic [11:0] DIR [ND] = '{
        {2'd0, 6'b000000, 4'd15}, {2'd0, 6'b000000, 4'd0},
        {2'd2, 6'b000000, 4'd0},  {2'd1, 6'b000001, 4'd0},
        {2'd1, 6'b010000, 4'd0},  {2'd0, 6'b001000, 4'd0},
        {2'd0, 6'b000100, 4'd0},  {2'd0, 6'b000000, 4'd3},
        {2'd0, 6'b011000, 4'd0},  {2'd0, 6'b001010, 4'd0},
        {2'd0, 6'b001001, 4'd0},  {2'd0, 6'b000001, 4'd0},
        {2'd0, 6'b010101, 4'd0},  {2'd0, 6'b011010, 4'd0},
        {2'd0, 6'b000111, 4'd0},  {2'd0, 6'b011101, 4'd0},
        {2'd0, 6'b100000, 4'd0},  {2'd3, 6'b111111, 4'd15}
    };

    task automatic rand_burst(int n);
        for (int i = 0; i < n; i++)
            drive(2'($urandom_range(3)), 6'($urandom), 4'($urandom));
    endtask

    initial begin
        rst_n = 1'b0;
        op = 2'd0; funct = 6'b001001; rd = 4'd0;
        #12;
        check("reset_zero", got(), 18'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'd0, 6'b001001, 4'd0);
        for (int i = 0; i < ND; i++)
            drive(DIR[i][11:10], DIR[i][9:4], DIR[i][3:0]);
        rand_burst(200);
        // Mid-stream reset discards the decode in flight
        op = 2'd2; funct = 6'($urandom); rd = 4'd15;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_zero", got(), 18'd0);
        @(negedge clk);
        check("midreset_hold", got(), 18'd0);
        exp_q.delete();
        rst_n = 1'b1;
        rand_burst(200);
        for (int k = 0; k < 5 && exp_q.size() > 0; k++)
            @(negedge clk);
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain left=%0d exp=0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
